// File: rtl/pakout_arb_pkg.sv
// Shared types, default sizes and size helpers for the pakout_arb packetiser.
package pakout_arb_pkg;

  // Default network sizes used when the instantiating level does not override them.
  localparam int NS_PACKET_SIZE       = 8;
  localparam int NS_MESSAGE_FIFO_SIZE = 4;
  localparam int NS_ADDRESS_SIZE      = 8;
  localparam int NS_DATA_SIZE         = 16;

  // Output serialiser states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_LOW = 2'd2
  } snd_state_e;

  // Number of PSZ-bit packets needed to carry an MSZ-bit message.
  function automatic int npak_f(input int msz, input int psz);
    return (msz + psz - 1) / psz;
  endfunction

  // Width of a channel index; never less than one bit.
  function automatic int csz_f(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/pakout_arb_fifo.sv
// pak_fifo: synchronous FIFO of 2**FSZ words of W bits. The head word is read
// straight out of the registered storage, so it is valid whenever empty is low.
module pakout_arb_fifo #(
  parameter int W   = 8,
  parameter int FSZ = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int DEPTH = 2 ** FSZ;
  localparam int CW    = FSZ + 1;

  logic [W-1:0]   mem_q [DEPTH];
  logic [FSZ-1:0] wr_q, wr_d;
  logic [FSZ-1:0] rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           push_s, pop_s;

  assign full   = (cnt_q == CW'(DEPTH));
  assign empty  = (cnt_q == {CW{1'b0}});
  // A full FIFO refuses a push even if a pop happens in the same cycle.
  assign push_s = push & ~full;
  assign pop_s  = pop & ~empty;
  assign rdata  = mem_q[rd_q];

  // Pointer and occupancy update; pointers wrap naturally at the depth.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_s) begin
      wr_d = wr_q + FSZ'(1);
    end else begin
      wr_d = wr_q;
    end
    if (pop_s) begin
      rd_d = rd_q + FSZ'(1);
    end else begin
      rd_d = rd_q;
    end
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q  <= {FSZ{1'b0}};
      rd_q  <= {FSZ{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Data storage; contents are don't-care until written so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_q] <= wdata;
    end
  end

endmodule

// File: rtl/pakout_arb.sv
// pakout_arb: round-robin multi-channel message packetiser for the NS network.
// Optional build macro NS_PAKOUT_SRC_TAG_EN prefixes each message with a header
// packet carrying the source channel index.
module pakout_arb
  import pakout_arb_pkg::*;
#(
  parameter int NCH = 2,
  parameter int PSZ = NS_PACKET_SIZE,
  parameter int FSZ = NS_MESSAGE_FIFO_SIZE,
  parameter int ASZ = NS_ADDRESS_SIZE,
  parameter int DSZ = NS_DATA_SIZE
) (
  input  logic                     i_clk,
  input  logic                     reset,
  output logic                     ready,
  input  logic [NCH-1:0]           rcv_req,
  input  logic [NCH*(ASZ+DSZ)-1:0] rcv_msg,
  output logic [NCH-1:0]           rcv_ack,
  output logic                     snd_req,
  output logic [PSZ-1:0]           snd_out_pak,
  output logic                     snd_last,
  input  logic                     snd_ack
);
  localparam int MSZ  = ASZ + DSZ;
  localparam int NPAK = npak_f(MSZ, PSZ);
  localparam int CSZ  = csz_f(NCH);
  localparam int BSZ  = NPAK * PSZ;
`ifdef NS_PAKOUT_SRC_TAG_EN
  localparam int NTOT = NPAK + 1;
  localparam int FW   = CSZ + MSZ;
`else
  localparam int NTOT = NPAK;
  localparam int FW   = MSZ;
`endif
  localparam int SW = NTOT * PSZ;
  localparam int IW = (NTOT > 1) ? $clog2(NTOT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NTOT - 1);

  logic           ready_q, ready_d;
  logic [NCH-1:0] ack_q, ack_d;
  logic [CSZ-1:0] ptr_q, ptr_d;
  logic           found_s, gnt_s;
  logic [CSZ-1:0] gnt_idx_s;
  logic [MSZ-1:0] gnt_msg_s;
  logic [FW-1:0]  push_data_s;
  logic [FW-1:0]  fifo_head_s;
  logic           fifo_full_s, fifo_empty_s, pop_s;
  logic [BSZ-1:0] body_s;
  logic [SW-1:0]  load_s;
  snd_state_e     state_q, state_d;
  logic [SW-1:0]  shift_q, shift_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           snd_req_q, snd_req_d;
  logic           snd_last_q, snd_last_d;

  // Channel examined at offset k from the round-robin pointer.
  function automatic int rr_chan(input logic [CSZ-1:0] p, input int k);
    return (int'(p) + k) % NCH;
  endfunction

  assign ready_d = 1'b1;

  // Round-robin search for the first eligible channel at or after the pointer.
  always_comb begin
    found_s   = 1'b0;
    gnt_idx_s = {CSZ{1'b0}};
    gnt_msg_s = {MSZ{1'b0}};
    for (int k = 0; k < NCH; k++) begin
      if (!found_s && rcv_req[rr_chan(ptr_q, k)] && !ack_q[rr_chan(ptr_q, k)]) begin
        found_s   = 1'b1;
        gnt_idx_s = CSZ'(rr_chan(ptr_q, k));
        gnt_msg_s = rcv_msg[rr_chan(ptr_q, k)*MSZ +: MSZ];
      end else begin
        found_s = found_s;
      end
    end
    // No grants before initialisation completes or while the FIFO is full.
    gnt_s = found_s & ready_q & ~fifo_full_s;
  end

  // Acknowledge regs follow the 4-phase protocol; pointer moves past the winner.
  always_comb begin
    ack_d = ack_q & rcv_req;
    ptr_d = ptr_q;
    if (gnt_s) begin
      ack_d[gnt_idx_s] = 1'b1;
      ptr_d            = CSZ'((int'(gnt_idx_s) + 1) % NCH);
    end else begin
      ptr_d = ptr_q;
    end
  end

`ifdef NS_PAKOUT_SRC_TAG_EN
  assign push_data_s = {gnt_idx_s, gnt_msg_s};
`else
  assign push_data_s = gnt_msg_s;
`endif

  pakout_arb_fifo #(
    .W   (FW),
    .FSZ (FSZ)
  ) u_fifo (
    .clk   (i_clk),
    .reset (reset),
    .push  (gnt_s),
    .pop   (pop_s),
    .wdata (push_data_s),
    .rdata (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

`ifdef NS_PAKOUT_SRC_TAG_EN
  logic [PSZ-1:0] hdr_s;

  // Shift-register image: header packet, then message MSB-aligned with zero pad.
  always_comb begin
    body_s               = {BSZ{1'b0}};
    body_s[BSZ-1 -: MSZ] = fifo_head_s[MSZ-1:0];
    hdr_s                = {PSZ{1'b0}};
    hdr_s[CSZ-1:0]       = fifo_head_s[FW-1 -: CSZ];
    load_s               = {hdr_s, body_s};
  end
`else
  // Shift-register image: message MSB-aligned with zero pad on the LSB side.
  always_comb begin
    body_s               = {BSZ{1'b0}};
    body_s[BSZ-1 -: MSZ] = fifo_head_s[MSZ-1:0];
    load_s               = body_s;
  end
`endif

  // Serialiser FSM: pop a message, then one full 4-phase handshake per packet.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    snd_req_d  = snd_req_q;
    snd_last_d = snd_last_q;
    pop_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ready_q && !fifo_empty_s) begin
          pop_s      = 1'b1;
          shift_d    = load_s;
          idx_d      = {IW{1'b0}};
          snd_req_d  = 1'b1;
          snd_last_d = (LAST_IDX == {IW{1'b0}});
          state_d    = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (snd_ack) begin
          snd_req_d  = 1'b0;
          snd_last_d = 1'b0;
          state_d    = ST_WAIT_LOW;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_WAIT_LOW: begin
        if (!snd_ack) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
          end else begin
            shift_d    = shift_q << PSZ;
            idx_d      = idx_q + IW'(1);
            snd_req_d  = 1'b1;
            snd_last_d = ((idx_q + IW'(1)) == LAST_IDX);
            state_d    = ST_SEND;
          end
        end else begin
          state_d = ST_WAIT_LOW;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        snd_req_d  = 1'b0;
        snd_last_d = 1'b0;
      end
    endcase
  end

  // All state registers; reset drops every handshake and the in-flight message.
  always_ff @(posedge i_clk) begin
    if (!reset) begin
      ready_q    <= 1'b0;
      ack_q      <= {NCH{1'b0}};
      ptr_q      <= {CSZ{1'b0}};
      state_q    <= ST_IDLE;
      shift_q    <= {SW{1'b0}};
      idx_q      <= {IW{1'b0}};
      snd_req_q  <= 1'b0;
      snd_last_q <= 1'b0;
    end else begin
      ready_q    <= ready_d;
      ack_q      <= ack_d;
      ptr_q      <= ptr_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      snd_req_q  <= snd_req_d;
      snd_last_q <= snd_last_d;
    end
  end

  assign ready       = ready_q;
  assign rcv_ack     = ack_q;
  assign snd_req     = snd_req_q;
  assign snd_last    = snd_last_q;
  assign snd_out_pak = shift_q[SW-1 -: PSZ];

endmodule
